// File: rtl/coll_pair_sched.sv
// Pair sequencer for coll_det: scans all i<j object pairs, one per cycle, queueing colliding pairs.
// Latency N_OBJ*(N_OBJ-1)/2 scan cycles plus stalls; done pulses two cycles after the last sample if the hit FIFO is empty.
// Backpressure: a full hit FIFO with trial=1 holds the current pair; optional COLL_SCAN_MASK_EN adds obj_active masking.
module coll_pair_sched #(
    parameter int N_OBJ      = 8,
    parameter int IDX_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [15:0]      wr_x,
    input  logic [15:0]      wr_y,
    input  logic [15:0]      wr_vx,
    input  logic [15:0]      wr_vy,
    input  logic [31:0]      r_thresh,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [15:0]      x1,
    output logic [15:0]      y1,
    output logic [15:0]      vx1,
    output logic [15:0]      vy1,
    output logic [15:0]      x2,
    output logic [15:0]      y2,
    output logic [15:0]      vx2,
    output logic [15:0]      vy2,
    output logic [31:0]      R,
    input  logic             trial,
`ifdef COLL_SCAN_MASK_EN
    input  logic [N_OBJ-1:0] obj_active,
`endif
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [IDX_W-1:0] hit_i,
    output logic [IDX_W-1:0] hit_j,
    output logic [15:0]      hit_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] vx;
        logic [15:0] vy;
    } obj_t;

    typedef struct packed {
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
    } pair_t;

    state_t           state_q, state_d;
    obj_t             obj_q [N_OBJ];
    obj_t             obj_d [N_OBJ];
    obj_t             p1_q, p2_q;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
    logic [31:0]      r_q, r_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             load_pair, push, pop, full, pair_act;

    pair_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   occ_q;

`ifdef COLL_SCAN_MASK_EN
    logic [N_OBJ-1:0] act_q, act_d;
    assign pair_act = act_q[i_q] & act_q[j_q];
`else
    assign pair_act = 1'b1;
`endif

    assign full      = (occ_q == (PTR_W+1)'(FIFO_DEPTH));
    assign hit_valid = (occ_q != '0);
    assign pop       = hit_valid & hit_ready;
    assign hit_i     = mem_q[rd_ptr_q].i;
    assign hit_j     = mem_q[rd_ptr_q].j;

    // Writes land in obj_d so a start in the same cycle already sees them.
    always_comb begin
        for (int k = 0; k < N_OBJ; k++) begin
            obj_d[k] = obj_q[k];
            if (wr_en && state_q == IDLE && wr_idx == IDX_W'(k)) begin
                obj_d[k] = '{x: wr_x, y: wr_y, vx: wr_vx, vy: wr_vy};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        load_pair = 1'b0;
        push      = 1'b0;
`ifdef COLL_SCAN_MASK_EN
        act_d     = act_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    r_d       = r_thresh;
                    i_d       = '0;
                    j_d       = IDX_W'(1);
                    cnt_d     = '0;
                    load_pair = 1'b1;
                    state_d   = SCAN;
`ifdef COLL_SCAN_MASK_EN
                    act_d     = obj_active;
`endif
                end
            end
            SCAN: begin
                if (!(trial && pair_act && full)) begin
                    if (trial && pair_act) begin
                        push = 1'b1;
                        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    end
                    if (i_q == IDX_W'(N_OBJ-2) && j_q == IDX_W'(N_OBJ-1)) begin
                        state_d = DRAIN;
                    end else begin
                        load_pair = 1'b1;
                        if (j_q < IDX_W'(N_OBJ-1)) begin
                            j_d = j_q + IDX_W'(1);
                        end else begin
                            i_d = i_q + IDX_W'(1);
                            j_d = i_q + IDX_W'(2);
                        end
                    end
                end
            end
            DRAIN: if (!hit_valid) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int k = 0; k < N_OBJ; k++) obj_q[k] <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
`ifdef COLL_SCAN_MASK_EN
            act_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            for (int k = 0; k < N_OBJ; k++) obj_q[k] <= obj_d[k];
            i_q     <= i_d;
            j_q     <= j_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
`ifdef COLL_SCAN_MASK_EN
            act_q   <= act_d;
`endif
            if (load_pair) begin
                p1_q <= obj_d[i_d];
                p2_q <= obj_d[j_d];
            end
        end
    end

    // Full is evaluated on current occupancy, so a same-cycle pop never makes room for a push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{i: i_q, j: j_q};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ_q <= occ_q + (PTR_W+1)'(1);
                2'b01:   occ_q <= occ_q - (PTR_W+1)'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign x1        = p1_q.x;
    assign y1        = p1_q.y;
    assign vx1       = p1_q.vx;
    assign vy1       = p1_q.vy;
    assign x2        = p2_q.x;
    assign y2        = p2_q.y;
    assign vx2       = p2_q.vx;
    assign vy2       = p2_q.vy;
    assign R         = r_q;
    assign hit_count = cnt_q;

endmodule

// File: tb/tb_coll_pair_sched.sv
// Randomized bench for coll_pair_sched: the trial stub and the hit/FIFO expectations come from a pair-list model.
module tb_coll_pair_sched;

    localparam int N  = 8;
    localparam int NP = N * (N - 1) / 2;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, start, trial, hit_ready;
    logic [2:0]  wr_idx;
    logic [15:0] wr_x, wr_y, wr_vx, wr_vy;
    logic [31:0] r_thresh;
    logic        busy, done, hit_valid;
    logic [15:0] x1, y1, vx1, vy1, x2, y2, vx2, vy2, hit_count;
    logic [31:0] R;
    logic [2:0]  hit_i, hit_j;
    logic [7:0]  obj_active;

    coll_pair_sched dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_x(wr_x), .wr_y(wr_y), .wr_vx(wr_vx), .wr_vy(wr_vy),
        .r_thresh(r_thresh), .start(start), .busy(busy), .done(done),
        .x1(x1), .y1(y1), .vx1(vx1), .vy1(vy1),
        .x2(x2), .y2(y2), .vx2(vx2), .vy2(vy2),
        .R(R), .trial(trial),
`ifdef COLL_SCAN_MASK_EN
        .obj_active(obj_active),
`endif
        .hit_valid(hit_valid), .hit_ready(hit_ready),
        .hit_i(hit_i), .hit_j(hit_j), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] mx [N], my [N], mvx [N], mvy [N];
    bit          hm [N][N];
    logic [7:0]  mact;
    logic [31:0] mr;
    int          fq [$];
    int          mcnt;
    int          pa_i [$], pa_j [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wr_obj(input int idx, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] vx, input logic [15:0] vy);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 3'(idx);
        wr_x = x; wr_y = y; wr_vx = vx; wr_vy = vy;
        mx[idx] = x; my[idx] = y; mvx[idx] = vx; mvy[idx] = vy;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++)
            wr_obj(k, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic set_hm(input int mode);
        for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
                hm[a][b] = (mode == 1) ? 1'b1 : (mode == 2) ? bit'($urandom_range(2) == 0) : 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_hvld"}, 64'(hit_valid), 0);
        chk({tag, "_hcnt"}, 64'(hit_count), 0);
        chk({tag, "_p1"}, {x1, y1, vx1, vy1}, 0);
        chk({tag, "_p2"}, {x2, y2, vx2, vy2}, 0);
        chk({tag, "_R"}, 64'(R), 0);
        chk({tag, "_hij"}, 64'({hit_i, hit_j}), 0);
    endtask

    task automatic run_scan(input string tag, input int hold, input int rdy_pct,
                            input bit junk, input bit wr_at_start, input int rst_at);
        int p, phase, pi, pj, occ, scan_cyc, stalls, cyc;
        bit h, hit, stall, pop, fin;
        p = 0; phase = 0; scan_cyc = 0; stalls = 0; fin = 0;
        @(negedge clk);
        chk({tag, "_idle_busy"}, 64'(busy), 0);
        start = 1'b1;
        r_thresh = $urandom;
        mr = r_thresh;
        obj_active = mact;
        if (wr_at_start) begin
            wr_en = 1'b1; wr_idx = 3'd1;
            wr_x = 16'($urandom); wr_y = 16'($urandom); wr_vx = 16'($urandom); wr_vy = 16'($urandom);
            mx[1] = wr_x; my[1] = wr_y; mvx[1] = wr_vx; mvy[1] = wr_vy;
        end
        mcnt = 0;
        @(posedge clk);
        #1 start = 1'b0; wr_en = 1'b0;
        for (cyc = 0; cyc < 2000 && !fin; cyc++) begin
            @(negedge clk);
            wr_en = 1'b0; start = 1'b0;
            hit_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            chk({tag, "_busy"}, 64'(busy), 1);
            chk({tag, "_done"}, 64'(done), 64'(phase == 2));
            chk({tag, "_hcnt"}, 64'(hit_count), 64'(mcnt));
            chk({tag, "_hvld"}, 64'(hit_valid), 64'(fq.size() != 0));
            if (fq.size() != 0) chk({tag, "_hpair"}, 64'({hit_i, hit_j}), 64'(fq[0]));
            if (cyc == rst_at) begin
                rst = 1'b1; trial = 1'b0;
                #1 chk_zero({tag, "_rst"});
                for (int k = 0; k < N; k++) begin
                    mx[k] = 0; my[k] = 0; mvx[k] = 0; mvy[k] = 0;
                end
                fq.delete();
                mcnt = 0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            occ = fq.size();
            pop = (occ > 0) && hit_ready;
            if (pop) void'(fq.pop_front());
            if (phase == 0) begin
                pi = pa_i[p]; pj = pa_j[p];
                chk({tag, "_p1"}, {x1, y1, vx1, vy1}, {mx[pi], my[pi], mvx[pi], mvy[pi]});
                chk({tag, "_p2"}, {x2, y2, vx2, vy2}, {mx[pj], my[pj], mvx[pj], mvy[pj]});
                chk({tag, "_R"}, 64'(R), 64'(mr));
                h = hm[pi][pj];
                trial = h;
                hit = h && mact[pi] && mact[pj];
                stall = hit && (occ == FD);
                if (junk && $urandom_range(3) == 0) begin
                    wr_en = 1'b1; wr_idx = 3'($urandom_range(N - 1));
                    wr_x = 16'($urandom); wr_y = 16'($urandom); wr_vx = 16'($urandom); wr_vy = 16'($urandom);
                    start = 1'b1;
                end
                scan_cyc++;
                if (stall) stalls++;
                else begin
                    if (hit) begin
                        fq.push_back(pi * 8 + pj);
                        mcnt++;
                    end
                    p++;
                    if (p == NP) phase = 1;
                end
            end else if (phase == 1) begin
                trial = 1'($urandom);
                if (occ == 0) phase = 2;
            end else begin
                trial = 1'($urandom);
                fin = 1;
            end
        end
        chk({tag, "_finished"}, 64'(fin), 1);
        chk({tag, "_scan_cycles"}, 64'(scan_cyc), 64'(NP + stalls));
        @(negedge clk);
        chk({tag, "_end_busy"}, 64'(busy), 0);
        chk({tag, "_end_done"}, 64'(done), 0);
        chk({tag, "_end_hvld"}, 64'(hit_valid), 0);
        chk({tag, "_end_hcnt"}, 64'(hit_count), 64'(mcnt));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; trial = 1'b0; hit_ready = 1'b0;
        wr_idx = '0; wr_x = '0; wr_y = '0; wr_vx = '0; wr_vy = '0; r_thresh = '0;
        mact = 8'hFF; obj_active = mact;
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++) begin
                pa_i.push_back(a); pa_j.push_back(b);
            end
        #3 chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        fill_random();
        set_hm(0);
        run_scan("nohit", 0, 100, 0, 0, -1);

        set_hm(0); hm[1][3] = 1'b1;
        run_scan("single", 0, 100, 0, 0, -1);

        set_hm(1);
        run_scan("allhit_bp", 20, 100, 0, 0, -1);

        wr_obj(2, 16'd100, 16'd200, 16'hFFFB, 16'd7);
        set_hm(2);
        run_scan("busy_wr", 0, 70, 1, 0, -1);
        set_hm(2);
        run_scan("after_wr", 0, 60, 0, 0, -1);
        run_scan("wr_start", 0, 80, 0, 1, -1);

        set_hm(0); hm[0][1] = 1'b1; hm[0][2] = 1'b1;
        run_scan("rst_mid", 100, 100, 0, 0, 10);
        run_scan("post_rst_zero", 0, 100, 0, 0, -1);
        fill_random();
        set_hm(2);
        run_scan("post_rst", 0, 50, 0, 0, -1);

`ifdef COLL_SCAN_MASK_EN
        mact = 8'b1111_0111;
        set_hm(1);
        run_scan("mask", 0, 100, 0, 0, -1);
        chk("mask_hits", 64'(hit_count), 21);
        mact = 8'hFF;
`endif

        for (int r = 0; r < 3; r++) begin
            set_hm(2);
            run_scan("rand", $urandom_range(15), $urandom_range(30, 90), 1, 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
